sobel_window_ctrl: RTL and testbench
====================================

SOBEL_WINDOW_CTRL -- requirements
Module: sobel_window_ctrl

Interface
REQ-001 SHALL provide parameter IMG_W, default 64, meaning image width in pixels (legal range 3..1024).
REQ-002 SHALL provide parameter IMG_H, default 64, meaning image height in lines (legal range 3..1024).
REQ-003 SHALL provide port clk  input  1  single clock; all logic updates on the rising edge.
REQ-004 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide port start  input  1  begin one frame; sampled only in IDLE.
REQ-006 SHALL provide port pix_valid  input  1  pix_data holds a valid raster-order pixel.
REQ-007 SHALL provide port pix_data  input  8  pixel value, unsigned.
REQ-008 SHALL provide port pix_ready  output  1  block accepts a pixel this cycle.
REQ-009 SHALL provide port flag  output  1  one-cycle strobe: el1..el9 form a valid window for the sobel datapath.
REQ-010 SHALL provide ports el1..el9  output  8 each  3x3 window, row-major: el1..el3 top row, el4..el6 middle row, el7..el9 bottom row, left to right.
REQ-011 SHALL provide ports win_row, win_col  output  10 each  centre coordinate of the current window.
REQ-012 SHALL provide port busy  output  1  frame in progress.
REQ-013 SHALL provide port done  output  1  one-cycle pulse at end of frame.

Function
REQ-014 SHALL implement FSM states IDLE, FILL, RUN, DONE.
- IDLE -> FILL on start=1.
- FILL -> RUN when pixel (row 1, col IMG_W-1) is accepted.
- RUN -> DONE when pixel (IMG_H-1, IMG_W-1) is accepted.
- DONE -> IDLE unconditionally after one cycle.
REQ-015 SHALL drive pix_ready=1 only in FILL and RUN.
- A pixel is accepted on a cycle with pix_valid & pix_ready.
REQ-016 SHALL maintain column and row counters that advance only on acceptance.
- Column wraps from IMG_W-1 to 0 and increments the row.
- Both counters clear on entry to FILL.
REQ-017 SHALL store the two previous lines in two line buffers of IMG_W x 8 bits and keep a 3x3 shift window.
- On each acceptance the window shifts left by one column.
- The new right column is {linebuf_older[col], linebuf_newer[col], pix_data}.
- The line buffers rotate at each column wrap.
REQ-018 SHALL assert flag for exactly one cycle, the cycle after accepting pixel (r,c) with r>=2 and c>=2.
- Latency is 1 cycle.
- On that cycle the window spans rows r-2..r and columns c-2..c.
- win_row=r-1 and win_col=c-1.
REQ-019 SHALL produce exactly (IMG_H-2)*(IMG_W-2) flag pulses per frame.
- No window may straddle a line wrap: columns 0 and 1 of each line never produce flag.
REQ-020 SHALL hold el1..el9, win_row and win_col stable whenever flag=0.
REQ-021 SHALL keep state, counters and outputs unchanged on stall cycles (pix_valid=0); no flag is generated.
REQ-022 SHALL ignore start outside IDLE.
REQ-023 SHALL drive busy=1 in FILL and RUN, and busy=0 in IDLE and DONE.
REQ-024 SHALL pulse done=1 for exactly the one cycle spent in DONE.
- This is the cycle after the final acceptance, so it coincides with the last flag.
REQ-025 SHALL permit start=1 in the DONE cycle to have no effect.
- A new frame requires start while in IDLE.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, set state=IDLE and row=col=0.
- Outputs: flag=0, done=0, busy=0, pix_ready=0, el1..el9=0, win_row=win_col=0.
REQ-027 SHALL let rst take priority over start, pix_valid and every FSM transition, including mid-frame.
REQ-028 SHALL NOT require line buffer contents to be cleared.
- After reset no flag may occur until two full new lines plus three pixels have been accepted.

Verification
REQ-029 SHALL cover 4x4 frame, pixel value = raster index 0..15, pix_valid held 1 -> exactly 4 flag pulses.
- First pulse: el1..el9 = 0,1,2,4,5,6,8,9,10 with win_row=1, win_col=1.
- Last pulse: 5,6,7,9,10,11,13,14,15.
- done pulses in the same cycle as the last flag.
REQ-030 SHALL cover IMG_W=IMG_H=3, pixel values 0..8 -> exactly one flag with el1..el9 = 0..8; busy falls the next cycle.
REQ-031 SHALL cover the 4x4 frame with pix_valid toggling 1,0,1,0 -> same 4 windows and values as REQ-029.
- No flag on or immediately after stall cycles.
REQ-032 SHALL cover rst=1 asserted after 10 pixels of a 4x4 frame -> next cycle busy=0, pix_ready=0, flag=0.
- A subsequent start plus a full frame yields the REQ-029 results exactly.
REQ-033 SHALL cover start pulsed during RUN and in the DONE cycle -> no restart, row/col unaffected, state reaches IDLE.
REQ-034 SHALL cover pix_valid=1 while in IDLE -> pix_ready=0, no pixel consumed, no flag.

Source files
------------

// File: rtl/sobel_window_ctrl.sv
// Raster-scan 3x3 window generator for a Sobel datapath: two rotating line
// buffers plus a shift window, framed by an IDLE/FILL/RUN/DONE controller.
module sobel_window_ctrl #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pix_valid,
  input  logic [7:0] pix_data,
  output logic       pix_ready,
  output logic       flag,
  output logic [7:0] el1,
  output logic [7:0] el2,
  output logic [7:0] el3,
  output logic [7:0] el4,
  output logic [7:0] el5,
  output logic [7:0] el6,
  output logic [7:0] el7,
  output logic [7:0] el8,
  output logic [7:0] el9,
  output logic [9:0] win_row,
  output logic [9:0] win_col,
  output logic       busy,
  output logic       done
);

  localparam int        AW       = $clog2(IMG_W);
  localparam logic [9:0] LAST_COL = 10'(IMG_W - 1);
  localparam logic [9:0] LAST_ROW = 10'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  state_t         state;
  logic [9:0]     row;
  logic [9:0]     col;
  logic           buf_sel;
  logic [7:0]     lbuf0 [IMG_W];
  logic [7:0]     lbuf1 [IMG_W];
  logic [7:0]     t0, t1, m0, m1, b0, b1;
  logic [7:0]     above2;
  logic [7:0]     above1;
  logic [AW-1:0]  addr;
  logic           accept;
  logic           last_col;
  logic           win_ok;

  assign accept   = pix_valid & pix_ready;
  assign addr     = col[AW-1:0];
  assign last_col = (col == LAST_COL);
  assign win_ok   = (row >= 10'd2) && (col >= 10'd2);

  // buf_sel names the buffer holding the older line; its slot is overwritten
  // with the current pixel right after being read, so a wrap just flips roles.
  assign above2 = buf_sel ? lbuf1[addr] : lbuf0[addr];
  assign above1 = buf_sel ? lbuf0[addr] : lbuf1[addr];

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      if (buf_sel) lbuf1[addr] <= pix_data;
      else         lbuf0[addr] <= pix_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      buf_sel   <= 1'b0;
      pix_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= FILL;
            row       <= '0;
            col       <= '0;
            pix_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        FILL, RUN: begin
          if (accept) begin
            col <= last_col ? 10'd0 : col + 10'd1;
            if (last_col) begin
              row     <= row + 10'd1;
              buf_sel <= ~buf_sel;
            end
            if (last_col && row == LAST_ROW) begin
              state     <= DONE;
              pix_ready <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else if (state == FILL && last_col && row == 10'd1) begin
              state <= RUN;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Two trailing columns shift on every pixel; the published window only
  // updates when a full 3x3 neighbourhood inside the current line exists.
  always_ff @(posedge clk) begin
    if (rst) begin
      {t0, t1, m0, m1, b0, b1} <= '0;
      {el1, el2, el3, el4, el5, el6, el7, el8, el9} <= '0;
      win_row <= '0;
      win_col <= '0;
      flag    <= 1'b0;
    end else begin
      flag <= 1'b0;
      if (accept) begin
        t0 <= t1;
        t1 <= above2;
        m0 <= m1;
        m1 <= above1;
        b0 <= b1;
        b1 <= pix_data;
        if (win_ok) begin
          flag    <= 1'b1;
          el1     <= t0;
          el2     <= t1;
          el3     <= above2;
          el4     <= m0;
          el5     <= m1;
          el6     <= above1;
          el7     <= b0;
          el8     <= b1;
          el9     <= pix_data;
          win_row <= row - 10'd1;
          win_col <= col - 10'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Self-checking bench: a 4x4 instance scored every cycle against a frame-array
// model, plus a directed 3x3 instance.
module tb_sobel_window_ctrl;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NPIX = W * H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, pix_valid;
  logic [7:0] pix_data;
  logic       a_ready, a_flag, a_busy, a_done;
  logic [7:0] a1, a2, a3, a4, a5, a6, a7, a8, a9;
  logic [9:0] a_row, a_col;
  logic [71:0] a_win;

  logic       b_rst, b_start, b_valid;
  logic [7:0] b_data;
  logic       b_ready, b_flag, b_busy, b_done;
  logic [7:0] c1, c2, c3, c4, c5, c6, c7, c8, c9;
  logic [9:0] b_row, b_col;
  logic [71:0] b_win;

  assign a_win = {a1, a2, a3, a4, a5, a6, a7, a8, a9};
  assign b_win = {c1, c2, c3, c4, c5, c6, c7, c8, c9};

  sobel_window_ctrl #(.IMG_W(W), .IMG_H(H)) dut_a (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(a_ready), .flag(a_flag),
    .el1(a1), .el2(a2), .el3(a3), .el4(a4), .el5(a5), .el6(a6), .el7(a7), .el8(a8), .el9(a9),
    .win_row(a_row), .win_col(a_col), .busy(a_busy), .done(a_done)
  );

  sobel_window_ctrl #(.IMG_W(3), .IMG_H(3)) dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .pix_valid(b_valid), .pix_data(b_data),
    .pix_ready(b_ready), .flag(b_flag),
    .el1(c1), .el2(c2), .el3(c3), .el4(c4), .el5(c5), .el6(c6), .el7(c7), .el8(c8), .el9(c9),
    .win_row(b_row), .win_col(b_col), .busy(b_busy), .done(b_done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit sim_end  = 1'b0;

  task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pixels are numbered in raster order within the frame and
  // each window is read straight out of the frame array.
  typedef enum int {M_IDLE, M_ACTIVE, M_DONE} mphase_t;
  mphase_t     m_phase = M_IDLE;
  int          m_k = 0;
  logic [7:0]  m_img [NPIX];
  logic        m_flag = 1'b0;
  logic [71:0] m_win = '0;
  logic [9:0]  m_row = '0, m_col = '0;
  bit          m_valid = 1'b0;

  int          cap_cnt = 0;
  int          cap_dones = 0;
  logic        cap_done_flag = 1'b0;
  logic [71:0] cap_first = '0, cap_last = '0;

  task automatic modelStep();
    int r, c;
    if (rst) begin
      m_phase = M_IDLE;
      m_k     = 0;
      m_flag  = 1'b0;
      m_win   = '0;
      m_row   = '0;
      m_col   = '0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_flag = 1'b0;
      case (m_phase)
        M_IDLE: if (start) begin
          m_phase = M_ACTIVE;
          m_k     = 0;
        end
        M_ACTIVE: if (pix_valid) begin
          r = m_k / W;
          c = m_k % W;
          m_img[m_k] = pix_data;
          if (r >= 2 && c >= 2) begin
            m_flag = 1'b1;
            m_row  = 10'(r - 1);
            m_col  = 10'(c - 1);
            for (int i = 0; i < 3; i++)
              for (int j = 0; j < 3; j++)
                m_win[71 - 8 * (3 * i + j) -: 8] = m_img[(r - 2 + i) * W + c - 2 + j];
          end
          m_k++;
          if (m_k == NPIX) m_phase = M_DONE;
        end
        default: m_phase = M_IDLE;
      endcase
    end
  endtask

  initial begin : scoreboard
    while (!sim_end) begin
      @(posedge clk);
      modelStep();
      @(negedge clk);
      if (m_valid) begin
        checkOutput("flag",      a_flag,  m_flag);
        checkOutput("done",      a_done,  m_phase == M_DONE);
        checkOutput("busy",      a_busy,  m_phase == M_ACTIVE);
        checkOutput("pix_ready", a_ready, m_phase == M_ACTIVE);
        checkOutput("window",    a_win,   m_win);
        checkOutput("win_row",   a_row,   m_row);
        checkOutput("win_col",   a_col,   m_col);
        if (a_flag) begin
          if (cap_cnt == 0) cap_first = a_win;
          cap_last = a_win;
          cap_cnt++;
        end
        if (a_done) begin
          cap_dones++;
          cap_done_flag = a_flag;
        end
      end
    end
  end

  task automatic applyStimulus(input logic st, input logic v, input logic [7:0] d, output logic acc);
    start     = st;
    pix_valid = v;
    pix_data  = d;
    acc       = v && a_ready;
    @(posedge clk);
    #1;
    start     = 1'b0;
    pix_valid = 1'b0;
  endtask

  // mode 0: valid held, 1: valid toggling, 2: random data/valid/start noise,
  // 3: valid held with start pulses mid-frame and on the DONE cycle
  task automatic runFrame(input int mode, input int stop_after);
    logic acc, v, st;
    logic [7:0] d;
    int idx, cyc;
    cap_cnt = 0;
    cap_dones = 0;
    cap_done_flag = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h00, acc);
    idx = 0;
    cyc = 0;
    while (idx < NPIX && cyc < 400 && idx != stop_after) begin
      v  = (mode == 1) ? (cyc % 2 == 0) : (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      d  = (mode == 2) ? 8'($urandom_range(0, 255)) : 8'(idx);
      st = (mode == 2) ? ($urandom_range(0, 4) == 0) : (mode == 3 && idx == 8);
      applyStimulus(st, v, d, acc);
      if (acc) idx++;
      cyc++;
    end
    if (stop_after < 0) begin
      checkOutput("frame_complete", idx, NPIX);
      applyStimulus(mode == 3, 1'b0, 8'h00, acc);
    end
  endtask

  task automatic checkRasterFrame(input string tag);
    checkOutput({tag, "_flag_count"}, cap_cnt, (H - 2) * (W - 2));
    checkOutput({tag, "_first_win"}, cap_first, {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10});
    checkOutput({tag, "_last_win"}, cap_last, {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15});
    checkOutput({tag, "_done_count"}, cap_dones, 1);
    checkOutput({tag, "_done_with_flag"}, cap_done_flag, 1'b1);
  endtask

  initial begin : main
    logic acc;
    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = '0;
    b_rst = 1'b1; b_start = 1'b0; b_valid = 1'b0; b_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset_busy", a_busy, 1'b0);
    checkOutput("reset_window", {a_win, a_row, a_col}, '0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h55, acc);
      checkOutput("idle_accept", acc, 1'b0);
    end

    runFrame(0, -1);
    checkRasterFrame("steady");
    runFrame(1, -1);
    checkRasterFrame("toggle");

    runFrame(0, 10);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("midreset_busy", a_busy, 1'b0);
    checkOutput("midreset_ready", a_ready, 1'b0);
    checkOutput("midreset_flag", a_flag, 1'b0);
    runFrame(0, -1);
    checkRasterFrame("after_reset");

    runFrame(3, -1);
    checkRasterFrame("start_noise");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00, acc);
    checkOutput("idle_after_noise", a_busy, 1'b0);

    for (int f = 0; f < 6; f++) begin
      runFrame(2, -1);
      checkOutput("random_flag_count", cap_cnt, (H - 2) * (W - 2));
    end

    // Directed 3x3 frame on the second instance
    #1 b_rst = 1'b0;
    @(posedge clk);
    #1 checkOutput("b_reset_busy", b_busy, 1'b0);
    b_start = 1'b1;
    @(posedge clk);
    #1 b_start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      checkOutput("b_busy", b_busy, 1'b1);
      checkOutput("b_ready", b_ready, 1'b1);
      b_valid = 1'b1;
      b_data  = 8'(i);
      @(posedge clk);
      #1;
      if (i < 8) checkOutput("b_flag_early", b_flag, 1'b0);
    end
    b_valid = 1'b0;
    checkOutput("b_flag", b_flag, 1'b1);
    checkOutput("b_done", b_done, 1'b1);
    checkOutput("b_window", b_win, 72'h000102030405060708);
    checkOutput("b_win_pos", {b_row, b_col}, {10'd1, 10'd1});
    checkOutput("b_busy_fell", b_busy, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("b_flag_after", b_flag, 1'b0);
    checkOutput("b_done_after", b_done, 1'b0);
    checkOutput("b_idle_busy", b_busy, 1'b0);

    sim_end = 1'b1;
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
